// File: rtl/matcher_pkg.sv
// -----------------------------------------------------------------------------
// matcher_pkg
//   Shared definitions for the tensor_core text matcher: default SRAM
//   address/data widths, the NUL character value and the state encoding
//   of the vocabulary scan sequencer.
// -----------------------------------------------------------------------------
package matcher_pkg;

  // Defaults shared by the matcher, its SRAMs and the scan sequencer.
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 8;

  // String terminator.
  localparam logic [DEF_DATA_WIDTH-1:0] NUL_CHAR = '0;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH      = 3'd1,
    CMP        = 3'd2,
    SKIP_FETCH = 3'd3,
    SKIP_CHK   = 3'd4,
    DONE       = 3'd5
  } vocab_scan_state_t;

endpackage : matcher_pkg

// File: rtl/vocab_scan_ctrl.sv
// -----------------------------------------------------------------------------
// vocab_scan_ctrl
//   Walks a vocabulary of NUL-terminated words stored back to back in the
//   vocab SRAM and compares each entry character by character against the
//   NUL-terminated word in the input SRAM. Reports the index and start
//   address of the first matching entry.
//
//   Handshake: a one-cycle 'start' is accepted only in IDLE; 'busy' is high
//   in every other state; 'done' pulses for one cycle (while in DONE) when
//   found/match_idx/match_addr are valid. The results hold until the next
//   accepted start.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   scan request (ignored unless IDLE)
//   vocab_addr, input_addr  registered SRAM read addresses
//   mem_cs                  SRAM chip select, high in FETCH/SKIP_FETCH
//   vocab_dout, input_dout  SRAM read data, valid the cycle after a fetch
//   busy, done              scan status
//   found, match_idx,
//   match_addr              scan result
// -----------------------------------------------------------------------------
module vocab_scan_ctrl
  import matcher_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] vocab_addr,
  output logic [ADDR_WIDTH-1:0] input_addr,
  output logic                  mem_cs,
  input  logic [DATA_WIDTH-1:0] vocab_dout,
  input  logic [DATA_WIDTH-1:0] input_dout,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [ADDR_WIDTH-1:0] match_idx,
  output logic [ADDR_WIDTH-1:0] match_addr
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  vocab_scan_state_t     r_state;
  logic [ADDR_WIDTH-1:0] r_vocab_addr;
  logic [ADDR_WIDTH-1:0] r_input_addr;
  logic [ADDR_WIDTH-1:0] r_word_start;
  logic [ADDR_WIDTH-1:0] r_word_idx;
  logic [ADDR_WIDTH-1:0] r_match_idx;
  logic [ADDR_WIDTH-1:0] r_match_addr;
  logic                  r_mem_cs;
  logic                  r_done;
  logic                  r_found;

  logic                  w_v_nul;
  logic                  w_w_nul;
  logic                  w_chars_eq;
  logic                  w_vocab_at_max;
  logic                  w_input_at_max;
  logic                  w_at_word_start;
  logic [ADDR_WIDTH-1:0] w_vocab_addr_inc;
  logic [ADDR_WIDTH-1:0] w_word_idx_inc;

  assign w_v_nul          = (vocab_dout == DATA_WIDTH'(NUL_CHAR));
  assign w_w_nul          = (input_dout == DATA_WIDTH'(NUL_CHAR));
  assign w_chars_eq       = (vocab_dout == input_dout);
  assign w_vocab_at_max   = (r_vocab_addr == ADDR_MAX);
  assign w_input_at_max   = (r_input_addr == ADDR_MAX);
  // A NUL at the first character of an entry is the end-of-vocab marker.
  assign w_at_word_start  = (r_vocab_addr == r_word_start);
  assign w_vocab_addr_inc = r_vocab_addr + ADDR_ONE;
  // The word counter sticks at all-ones instead of wrapping to 0.
  assign w_word_idx_inc   = w_at_max_idx(r_word_idx) ? r_word_idx : r_word_idx + ADDR_ONE;

  function automatic logic w_at_max_idx(input logic [ADDR_WIDTH-1:0] idx);
    return (idx == ADDR_MAX);
  endfunction

  // Single FSM: mem_cs and done are registered alongside the state so that
  // mem_cs is high exactly in FETCH/SKIP_FETCH and done exactly in DONE.
  // "Go to DONE with found=0" needs no write to found: it was cleared when
  // the scan was accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_vocab_addr <= '0;
      r_input_addr <= '0;
      r_word_start <= '0;
      r_word_idx   <= '0;
      r_match_idx  <= '0;
      r_match_addr <= '0;
      r_mem_cs     <= 1'b0;
      r_done       <= 1'b0;
      r_found      <= 1'b0;
    end else begin
      r_mem_cs <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_vocab_addr <= '0;
            r_input_addr <= '0;
            r_word_start <= '0;
            r_word_idx   <= '0;
            r_found      <= 1'b0;
            r_match_idx  <= '0;
            r_match_addr <= '0;
            r_mem_cs     <= 1'b1;
            r_state      <= FETCH;
          end
        end

        FETCH:      r_state <= CMP;
        SKIP_FETCH: r_state <= SKIP_CHK;

        CMP: begin
          if (w_v_nul && w_at_word_start) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (w_v_nul && w_w_nul) begin
            r_found      <= 1'b1;
            r_match_idx  <= r_word_idx;
            r_match_addr <= r_word_start;
            r_done       <= 1'b1;
            r_state      <= DONE;
          end else if (w_chars_eq) begin
            if (w_vocab_at_max || w_input_at_max) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_vocab_addr <= w_vocab_addr_inc;
              r_input_addr <= r_input_addr + ADDR_ONE;
              r_mem_cs     <= 1'b1;
              r_state      <= FETCH;
            end
          end else if (w_v_nul) begin
            // Entry shorter than the input: move on to the next entry.
            if (w_vocab_at_max) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_word_start <= w_vocab_addr_inc;
              r_vocab_addr <= w_vocab_addr_inc;
              r_input_addr <= '0;
              r_word_idx   <= w_word_idx_inc;
              r_mem_cs     <= 1'b1;
              r_state      <= FETCH;
            end
          end else begin
            // Mismatch: skip the rest of this entry up to its NUL.
            if (w_vocab_at_max) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_vocab_addr <= w_vocab_addr_inc;
              r_mem_cs     <= 1'b1;
              r_state      <= SKIP_FETCH;
            end
          end
        end

        SKIP_CHK: begin
          if (w_v_nul) begin
            if (w_vocab_at_max) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_word_start <= w_vocab_addr_inc;
              r_vocab_addr <= w_vocab_addr_inc;
              r_input_addr <= '0;
              r_word_idx   <= w_word_idx_inc;
              r_mem_cs     <= 1'b1;
              r_state      <= FETCH;
            end
          end else if (w_vocab_at_max) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_vocab_addr <= w_vocab_addr_inc;
            r_mem_cs     <= 1'b1;
            r_state      <= SKIP_FETCH;
          end
        end

        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign vocab_addr = r_vocab_addr;
  assign input_addr = r_input_addr;
  assign mem_cs     = r_mem_cs;
  assign busy       = (r_state != IDLE);
  assign done       = r_done;
  assign found      = r_found;
  assign match_idx  = r_match_idx;
  assign match_addr = r_match_addr;

endmodule : vocab_scan_ctrl

// File: tb/tb_vocab_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vocab_scan_ctrl
//   Directed scans against behavioural one-cycle-read SRAMs. Expected
//   results are queued when a scan is started; a monitor pops and compares
//   whenever done is seen.
// -----------------------------------------------------------------------------
module tb_vocab_scan_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int EW = 21; // {found, idx[3:0], addr[3:0], end_addr[3:0], lat[7:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [AW-1:0] vocab_addr, input_addr, match_idx, match_addr;
  logic          mem_cs, busy, done, found;
  logic [DW-1:0] vocab_dout = '0;
  logic [DW-1:0] input_dout = '0;

  vocab_scan_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .vocab_addr (vocab_addr),
    .input_addr (input_addr),
    .mem_cs     (mem_cs),
    .vocab_dout (vocab_dout),
    .input_dout (input_dout),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .match_idx  (match_idx),
    .match_addr (match_addr)
  );

  // ---------------- SRAM models ----------------
  logic [DW-1:0] vmem [16];
  logic [DW-1:0] imem [16];

  always @(posedge clk) begin
    if (mem_cs) begin
      vocab_dout <= vmem[vocab_addr];
      input_dout <= imem[input_addr];
    end
  end

  // '|' in the load strings stands for NUL; unused cells hold '~'.
  task automatic load_vocab(input string s);
    for (int i = 0; i < 16; i++) vmem[i] = 8'h7e;
    for (int i = 0; i < s.len() && i < 16; i++) vmem[i] = (s[i] == "|") ? 8'h00 : s[i];
  endtask

  task automatic load_input(input string s);
    for (int i = 0; i < 16; i++) imem[i] = 8'h7e;
    for (int i = 0; i < s.len() && i < 16; i++) imem[i] = (s[i] == "|") ? 8'h00 : s[i];
  endtask

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  int cyc = 0;
  int start_cyc = 0;
  logic [EW-1:0] exp_q[$];
  logic chk_done_drop = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [EW-1:0] mk_exp(input logic f, input logic [3:0] idx,
                                           input logic [3:0] addr, input logic [3:0] end_addr,
                                           input int lat);
    return {f, idx, addr, end_addr, 8'(lat)};
  endfunction

  // Monitor: compare on done, then confirm done is a single-cycle pulse.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n) begin
      if (chk_done_drop) begin
        check("done_pulse_width", {31'd0, done}, 32'd0);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        chk_done_drop = 1'b0;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: got done with empty queue required none");
        end else begin
          e = exp_q.pop_front();
          check("found",      {31'd0, found},      {31'd0, e[20]});
          check("match_idx",  {28'd0, match_idx},  {28'd0, e[19:16]});
          check("match_addr", {28'd0, match_addr}, {28'd0, e[15:12]});
          check("end_addr",   {28'd0, vocab_addr}, {28'd0, e[11:8]});
          check("latency",    cyc - start_cyc + 1, {24'd0, e[7:0]});
          check("busy_in_done", {31'd0, busy}, 32'd1);
        end
        chk_done_drop = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_start(input logic [EW-1:0] e, input bit push);
    @(negedge clk);
    start = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  // Returns at the negedge where done is seen; expired bound counts as a failure.
  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_total++;
      $display("FAIL done_timeout: got no done in 200 cycles required done");
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vocab_addr"}, {28'd0, vocab_addr}, 32'd0);
    check({tag, "_input_addr"}, {28'd0, input_addr}, 32'd0);
    check({tag, "_mem_cs"},     {31'd0, mem_cs},     32'd0);
    check({tag, "_busy"},       {31'd0, busy},       32'd0);
    check({tag, "_done"},       {31'd0, done},       32'd0);
    check({tag, "_found"},      {31'd0, found},      32'd0);
    check({tag, "_match_idx"},  {28'd0, match_idx},  32'd0);
    check({tag, "_match_addr"}, {28'd0, match_addr}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    load_vocab("cat|dog||");
    load_input("dog|");
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: match in second entry, 8 characters examined -> 17 cycles.
    issue_start(mk_exp(1'b1, 4'd1, 4'd4, 4'd7, 17), 1'b1);
    wait_done();
    @(negedge clk);

    // 2: no match, ends at the marker; a start while busy must be ignored.
    load_input("cow|");
    issue_start(mk_exp(1'b0, 4'd0, 4'd0, 4'd8, 19), 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);

    // 3: entry ends early (rule 4), match in the following entry.
    load_vocab("do|dog||");
    load_input("dog|");
    issue_start(mk_exp(1'b1, 4'd1, 4'd3, 4'd6, 15), 1'b1);
    wait_done();
    // start coincident with done must not launch a new scan
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("start_during_done_ignored", {31'd0, busy}, 32'd0);
    check("result_held_found", {31'd0, found}, 32'd1);
    repeat (2) @(negedge clk);

    // 4: 16 non-NUL characters without terminator: stop at addr 15, no wrap.
    load_vocab("qqqqqqqqqqqqqqqq");
    load_input("xyz|");
    issue_start(mk_exp(1'b0, 4'd0, 4'd0, 4'd15, 33), 1'b1);
    wait_done();
    repeat (3) @(negedge clk);

    // 5: empty input word never matches.
    load_vocab("a||");
    load_input("|");
    issue_start(mk_exp(1'b0, 4'd0, 4'd0, 4'd2, 7), 1'b1);
    wait_done();
    @(negedge clk);

    // 6: reset asserted in SKIP_CHK of the "dog" scan, then a clean restart.
    load_vocab("cat|dog||");
    load_input("dog|");
    issue_start('0, 1'b0);
    repeat (4) @(negedge clk);
    check("mid_scan_busy", {31'd0, busy}, 32'd1);
    check("mid_scan_vocab_addr", {28'd0, vocab_addr}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue_start(mk_exp(1'b1, 4'd1, 4'd4, 4'd7, 17), 1'b1);
    wait_done();
    repeat (3) @(negedge clk);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_vocab_scan_ctrl
